// File: rtl/if_id_stage.sv
// IF/ID pipeline register: captures the fetched instruction and PC+4, then splits the
// held instruction into decode fields with extender mode and illegal-opcode detection.
module if_id_stage #(
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
   parameter int          CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      if_instr,
   input  logic [31:0]      if_pc4,
   input  logic             if_valid,
   input  logic             stall,
   input  logic             flush,
   output logic [31:0]      id_instr,
   output logic [31:0]      id_pc4,
   output logic             id_valid,
   output logic [5:0]       opcode,
   output logic [4:0]       rs,
   output logic [4:0]       rt,
   output logic [4:0]       rd,
   output logic [4:0]       shamt,
   output logic [5:0]       funct,
   output logic [15:0]      imm,
   output logic [25:0]      jaddr,
   output logic             ExtOp,
   output logic             illegal,
   output logic [CNT_W-1:0] stall_cnt
);

   logic [31:0]      instr_q, instr_d;
   logic [31:0]      pc4_q, pc4_d;
   logic             valid_q, valid_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ext_s, sup_s;

   // Next-state selection: flush beats stall, stall beats load
   always_comb begin
      instr_d = instr_q;
      pc4_d   = pc4_q;
      valid_d = valid_q;
      cnt_d   = cnt_q;
      if (flush) begin
         instr_d = NOP_INSTR;
         pc4_d   = 32'h0000_0000;
         valid_d = 1'b0;
      end else if (stall) begin
         instr_d = instr_q;
         pc4_d   = pc4_q;
         valid_d = valid_q;
      end else begin
         instr_d = if_instr;
         pc4_d   = if_pc4;
         valid_d = if_valid;
      end
      // Only stalls of a real instruction are counted, and the count saturates
      if (!flush && stall && valid_q && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Pipeline and counter registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         instr_q <= NOP_INSTR;
         pc4_q   <= 32'h0000_0000;
         valid_q <= 1'b0;
         cnt_q   <= {CNT_W{1'b0}};
      end else begin
         instr_q <= instr_d;
         pc4_q   <= pc4_d;
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
      end
   end

   // Opcode classification: supported set and immediate extension mode
   always_comb begin
      ext_s = 1'b0;
      sup_s = 1'b0;
      case (instr_q[31:26])
         6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B,
         6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B: begin
            ext_s = 1'b1;
            sup_s = 1'b1;
         end
         6'h00, 6'h02, 6'h03, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
            ext_s = 1'b0;
            sup_s = 1'b1;
         end
         default: begin
            ext_s = 1'b0;
            sup_s = 1'b0;
         end
      endcase
   end

   assign id_instr  = instr_q;
   assign id_pc4    = pc4_q;
   assign id_valid  = valid_q;
   assign stall_cnt = cnt_q;
   assign opcode    = instr_q[31:26];
   assign rs        = instr_q[25:21];
   assign rt        = instr_q[20:16];
   assign rd        = instr_q[15:11];
   assign shamt     = instr_q[10:6];
   assign funct     = instr_q[5:0];
   assign imm       = instr_q[15:0];
   assign jaddr     = instr_q[25:0];
   assign ExtOp     = valid_q & ext_s;
   assign illegal   = valid_q & ~sup_s;

endmodule

// File: tb/tb_if_id_stage.sv
// Scoreboard bench for if_id_stage: stimulus pushes expected state and hand-computed
// field values into queues; a negedge monitor pops and compares them.
module tb_if_id_stage;

   logic        clk = 1'b0;
   logic        rst, if_valid, stall, flush;
   logic [31:0] if_instr, if_pc4;
   logic [31:0] id_instr, id_pc4;
   logic        id_valid, ExtOp, illegal;
   logic [5:0]  opcode, funct;
   logic [4:0]  rs, rt, rd, shamt;
   logic [15:0] imm;
   logic [25:0] jaddr;
   logic [3:0]  stall_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   if_id_stage #(.NOP_INSTR(32'h0000_0000), .CNT_W(4)) dut (
      .clk(clk), .rst(rst), .if_instr(if_instr), .if_pc4(if_pc4), .if_valid(if_valid),
      .stall(stall), .flush(flush), .id_instr(id_instr), .id_pc4(id_pc4),
      .id_valid(id_valid), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
      .funct(funct), .imm(imm), .jaddr(jaddr), .ExtOp(ExtOp), .illegal(illegal),
      .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc4;
      logic        valid;
      logic        ext;
      logic        ill;
      logic [3:0]  cnt;
   } exp_t;

   typedef struct {
      string       name;
      int          sel;
      logic [31:0] val;
   } hand_t;

   exp_t  exp_q[$];
   hand_t hand_q[$];

   // Reference model state
   logic [31:0] m_instr, m_pc4;
   logic        m_valid;
   logic [3:0]  m_cnt;

   logic [5:0] ext1_ops [14] = '{6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h20,
                                 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B};
   logic [5:0] ext0_ops [7]  = '{6'h00, 6'h02, 6'h03, 6'h0C, 6'h0D, 6'h0E, 6'h0F};

   function automatic logic in_list1(input logic [5:0] op);
      for (int i = 0; i < 14; i++) if (ext1_ops[i] == op) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic in_list0(input logic [5:0] op);
      for (int i = 0; i < 7; i++) if (ext0_ops[i] == op) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] actual(input int sel);
      case (sel)
         0: return id_instr;
         1: return {26'd0, opcode};
         2: return {27'd0, rt};
         3: return {16'd0, imm};
         4: return {31'd0, ExtOp};
         5: return {31'd0, illegal};
         6: return {31'd0, id_valid};
         7: return {28'd0, stall_cnt};
         8: return id_pc4;
         default: return 32'hDEAD_BEEF;
      endcase
   endfunction

   task automatic step(input logic r, input logic st, input logic fl, input logic v,
                       input logic [31:0] ins, input logic [31:0] pc);
      exp_t e;
      rst = r; stall = st; flush = fl; if_valid = v; if_instr = ins; if_pc4 = pc;
      @(posedge clk);
      #1;
      if (r) begin
         m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_cnt = 4'd0;
      end else if (fl) begin
         m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
      end else if (st) begin
         if (m_valid && m_cnt != 4'd15) m_cnt = m_cnt + 4'd1;
      end else begin
         m_instr = ins; m_pc4 = pc; m_valid = v;
      end
      e.instr = m_instr;
      e.pc4   = m_pc4;
      e.valid = m_valid;
      e.ext   = m_valid & in_list1(m_instr[31:26]);
      e.ill   = m_valid & ~(in_list1(m_instr[31:26]) | in_list0(m_instr[31:26]));
      e.cnt   = m_cnt;
      exp_q.push_back(e);
   endtask

   task automatic hand(input string name, input int sel, input logic [31:0] val);
      hand_t h;
      h.name = name; h.sel = sel; h.val = val;
      hand_q.push_back(h);
   endtask

   // Monitor: compare everything queued since the last edge
   always @(negedge clk) begin
      while (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         n_checks++;
         if ({id_instr, id_pc4, id_valid, ExtOp, illegal, stall_cnt} !==
             {e.instr, e.pc4, e.valid, e.ext, e.ill, e.cnt} ||
             {opcode, rs, rt, rd, shamt, funct} !== e.instr ||
             imm !== e.instr[15:0] || jaddr !== e.instr[25:0]) begin
            n_fail++;
            $display("FAIL state: got instr=%h pc4=%h v=%b ext=%b ill=%b cnt=%0d, want instr=%h pc4=%h v=%b ext=%b ill=%b cnt=%0d",
                     id_instr, id_pc4, id_valid, ExtOp, illegal, stall_cnt,
                     e.instr, e.pc4, e.valid, e.ext, e.ill, e.cnt);
         end
      end
      while (hand_q.size() > 0) begin
         hand_t h;
         h = hand_q.pop_front();
         n_checks++;
         if (actual(h.sel) !== h.val) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", h.name, actual(h.sel), h.val);
         end
      end
   end

   initial begin
      rst = 1'b1; stall = 1'b0; flush = 1'b0; if_valid = 1'b0;
      if_instr = 32'h0; if_pc4 = 32'h0;
      #1;
      // Reset for two cycles
      step(1'b1, 1'b0, 1'b0, 1'b1, 32'h1234_5678, 32'h0000_0100);
      step(1'b1, 1'b0, 1'b0, 1'b1, 32'h1234_5678, 32'h0000_0100);
      hand("rst_instr", 0, 32'h0); hand("rst_valid", 6, 32'h0);
      hand("rst_cnt", 7, 32'h0); hand("rst_ext", 4, 32'h0); hand("rst_pc4", 8, 32'h0);
      // addi: sign extend
      step(1'b0, 1'b0, 1'b0, 1'b1, 32'h2008_FFFF, 32'h0000_0004);
      hand("addi_opcode", 1, 32'h8); hand("addi_rt", 2, 32'h8);
      hand("addi_imm", 3, 32'hFFFF); hand("addi_ext", 4, 32'h1);
      hand("addi_valid", 6, 32'h1); hand("addi_pc4", 8, 32'h4);
      // ori: zero extend
      step(1'b0, 1'b0, 1'b0, 1'b1, 32'h3508_00FF, 32'h0000_0008);
      hand("ori_ext", 4, 32'h0); hand("ori_imm", 3, 32'h00FF); hand("ori_ill", 5, 32'h0);
      // R-type add
      step(1'b0, 1'b0, 1'b0, 1'b1, 32'h012A_4020, 32'h0000_000C);
      hand("add_ext", 4, 32'h0); hand("add_ill", 5, 32'h0);
      // lw then 3-cycle stall with changing fetch
      step(1'b0, 1'b0, 1'b0, 1'b1, 32'h8D09_0004, 32'h0000_0010);
      hand("lw_ext", 4, 32'h1);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b1, 1'b0, 1'b1, 32'h1111_1111 * (i + 1), 32'h0000_0014);
         hand("stall_hold", 0, 32'h8D09_0004);
      end
      hand("stall_cnt3", 7, 32'h3);
      step(1'b0, 1'b0, 1'b0, 1'b1, 32'h2000_0001, 32'h0000_0020);
      hand("after_stall", 0, 32'h2000_0001);
      // stall + flush together: bubble, counter unchanged
      step(1'b0, 1'b1, 1'b1, 1'b1, 32'h2000_0002, 32'h0000_0024);
      hand("flush_valid", 6, 32'h0); hand("flush_instr", 0, 32'h0);
      hand("flush_ext", 4, 32'h0); hand("flush_cnt", 7, 32'h3);
      for (int i = 0; i < 2; i++) begin
         step(1'b0, 1'b1, 1'b0, 1'b1, 32'h2000_0003, 32'h0000_0028);
         hand("bubble_cnt", 7, 32'h3); hand("bubble_valid", 6, 32'h0);
      end
      // Illegal opcode with and without valid
      step(1'b0, 1'b0, 1'b0, 1'b1, 32'hFC00_0000, 32'h0000_0030);
      hand("ill_v1", 5, 32'h1); hand("ill_v1_ext", 4, 32'h0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 32'hFC00_0000, 32'h0000_0034);
      hand("ill_v0", 5, 32'h0); hand("ill_v0_instr", 0, 32'hFC00_0000);
      // Saturation: 20 stall cycles on a valid lw
      step(1'b0, 1'b0, 1'b0, 1'b1, 32'h8D09_0004, 32'h0000_0038);
      for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 32'h0);
      hand("sat_cnt", 7, 32'hF);
      // Reset overrides simultaneous stall and flush
      step(1'b1, 1'b1, 1'b1, 1'b1, 32'h2008_FFFF, 32'h0000_0040);
      hand("rst_over_cnt", 7, 32'h0); hand("rst_over_valid", 6, 32'h0);
      step(1'b0, 1'b0, 1'b0, 1'b1, 32'h2008_FFFF, 32'h0000_0044);
      hand("reload_ext", 4, 32'h1);
      @(negedge clk);
      #1;
      n_checks++;
      if (exp_q.size() != 0 || hand_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d entries left, want 0", exp_q.size() + hand_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
